regfile_wb: RTL

- 32-entry general-purpose register file for the five-stage MIPS CPU.
- Consumes the writeback stream produced by stage 5 (regwrite, wrreg, wrdata) and serves the two decode-stage read ports.
- Adds a serial diagnostic dump engine that streams every register over a valid/ready handshake for bench and debug inspection.

---
 rtl/regfile_wb_pkg.sv | 13 +
 rtl/regfile_wb_if.sv | 34 +++
 rtl/regfile_wb_dump_fsm.sv | 77 +++++++
 rtl/regfile_wb.sv | 73 +++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared constants for the writeback register file and its dump engine.
// The dump FSM state encoding lives here so the bench and RTL agree on it.
package regfile_wb_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int AWIDTH_DEF = 5;
  localparam int NUM_REGS   = 2 ** AWIDTH_DEF;
  localparam int REG_ZERO   = 0;

  localparam logic [0:0] DUMP_IDLE = 1'b0;
  localparam logic [0:0] DUMP_SEND = 1'b1;

endpackage

// File: rtl/regfile_wb_if.sv
// Bundles the decode read ports, the writeback stream and the dump handshake.
// The slave modport is the register file side; the master modport is the CPU/bench side.
interface regfile_wb_if
  import regfile_wb_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) ();

  logic [AWIDTH-1:0] rdreg1;
  logic [AWIDTH-1:0] rdreg2;
  logic [DWIDTH-1:0] rddata1;
  logic [DWIDTH-1:0] rddata2;
  logic              regwrite;
  logic [AWIDTH-1:0] wrreg;
  logic [DWIDTH-1:0] wrdata;
  logic              dump_start;
  logic              dump_busy;
  logic              dump_valid;
  logic              dump_ready;
  logic [AWIDTH-1:0] dump_idx;
  logic [DWIDTH-1:0] dump_data;

  modport slave (
    input  rdreg1, rdreg2, regwrite, wrreg, wrdata, dump_start, dump_ready,
    output rddata1, rddata2, dump_busy, dump_valid, dump_idx, dump_data
  );

  modport master (
    output rdreg1, rdreg2, regwrite, wrreg, wrdata, dump_start, dump_ready,
    input  rddata1, rddata2, dump_busy, dump_valid, dump_idx, dump_data
  );

endinterface

// File: rtl/regfile_wb_dump_fsm.sv
// Serial dump engine: walks every register index once per dump_start and presents
// each word on a valid/ready handshake, sampling the array through a dedicated read port.
module regfile_dump_fsm
  import regfile_wb_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_start_i,
  input  logic              dump_ready_i,
  output logic              dump_busy_o,
  output logic              dump_valid_o,
  output logic [AWIDTH-1:0] dump_idx_o,
  output logic [DWIDTH-1:0] dump_data_o,
  output logic [AWIDTH-1:0] rd_addr_o,
  input  logic [DWIDTH-1:0] rd_data_i
);

  logic [0:0]        state_q, state_d;
  logic [AWIDTH-1:0] idx_q, idx_d;
  logic [DWIDTH-1:0] data_q, data_d;

  // The read port always looks one index ahead so the next word is ready at the handshake.
  assign rd_addr_o = (state_q == DUMP_SEND) ? idx_q + 1'b1 : '0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      DUMP_IDLE: begin
        if (dump_start_i) begin
          state_d = DUMP_SEND;
          idx_d   = '0;
          data_d  = rd_data_i;
        end
      end
      DUMP_SEND: begin
        if (dump_ready_i) begin
          if (idx_q == '1) begin
            state_d = DUMP_IDLE;
            idx_d   = '0;
            data_d  = '0;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = rd_data_i;
          end
        end
      end
      default: begin
        state_d = DUMP_IDLE;
        idx_d   = '0;
        data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign dump_busy_o  = (state_q == DUMP_SEND);
  assign dump_valid_o = (state_q == DUMP_SEND);
  assign dump_idx_o   = idx_q;
  assign dump_data_o  = data_q;

endmodule

// File: rtl/regfile_wb.sv
// 32-entry MIPS register file fed by the writeback stage, with two decode read ports and a dump engine.
// Define REGFILE_WB_BYPASS_EN to forward a same-cycle writeback onto every read port.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input logic         clk,
  input logic         rst,
  regfile_wb_if.slave rf
);

  localparam int NumEntries = 2 ** AWIDTH;
  localparam logic [AWIDTH-1:0] ZeroAddr = AWIDTH'(REG_ZERO);

  logic [DWIDTH-1:0] regs_q [NumEntries];
  logic [DWIDTH-1:0] regs_d [NumEntries];
  logic              wrEn;
  logic [AWIDTH-1:0] dumpAddr;
  logic [DWIDTH-1:0] dumpRdData;

  assign wrEn = rf.regwrite && (rf.wrreg != ZeroAddr);

  always_comb begin
    regs_d = regs_q;
    if (wrEn) begin
      regs_d[rf.wrreg] = rf.wrdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumEntries; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Address zero is hardwired to 0 on every port, bypass or not.
  always_comb begin
    rf.rddata1 = regs_q[rf.rdreg1];
    rf.rddata2 = regs_q[rf.rdreg2];
    dumpRdData = regs_q[dumpAddr];
`ifdef REGFILE_WB_BYPASS_EN
    if (wrEn && (rf.rdreg1 == rf.wrreg)) rf.rddata1 = rf.wrdata;
    if (wrEn && (rf.rdreg2 == rf.wrreg)) rf.rddata2 = rf.wrdata;
    if (wrEn && (dumpAddr == rf.wrreg))  dumpRdData = rf.wrdata;
`endif
    if (rf.rdreg1 == ZeroAddr) rf.rddata1 = '0;
    if (rf.rdreg2 == ZeroAddr) rf.rddata2 = '0;
    if (dumpAddr == ZeroAddr)  dumpRdData = '0;
  end

  regfile_dump_fsm #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH)
  ) u_dump (
    .clk          (clk),
    .rst          (rst),
    .dump_start_i (rf.dump_start),
    .dump_ready_i (rf.dump_ready),
    .dump_busy_o  (rf.dump_busy),
    .dump_valid_o (rf.dump_valid),
    .dump_idx_o   (rf.dump_idx),
    .dump_data_o  (rf.dump_data),
    .rd_addr_o    (dumpAddr),
    .rd_data_i    (dumpRdData)
  );

endmodule
